console_uart_tx: RTL and testbench

//  Memory-mapped console output peripheral on the core's data memory interface, downstream of phoeniX.

---
 rtl/console_uart_tx.sv | 199 +++++++++++++++++++
 tb/tb_console_uart_tx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/console_uart_tx.sv
// Memory-mapped console: byte stores to CONSOLE_ADDRESS are queued in a FIFO and
// sent as 8N1 UART; a status word at CONSOLE_ADDRESS+4 reports level, busy and overflow.
module console_uart_tx #(
    parameter logic [31:0] CONSOLE_ADDRESS = 32'h1000_0000,
    parameter int          FIFO_DEPTH      = 16,
    parameter int          CLKS_PER_BIT    = 868
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        data_memory_interface_enable,
    input  logic        data_memory_interface_state,
    input  logic [31:0] data_memory_interface_address,
    input  logic [3:0]  data_memory_interface_frame_mask,
    input  logic [31:0] data_memory_interface_data,
    output logic [31:0] read_data,
    output logic        read_hit,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(CLKS_PER_BIT);

    // Encoding of the core's `READ / `WRITE access-direction macros
    localparam logic STATE_READ  = 1'b0;
    localparam logic STATE_WRITE = 1'b1;

    localparam logic [31:0] STATUS_ADDRESS = CONSOLE_ADDRESS + 32'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } tx_state_t;

    tx_state_t      r_state;
    logic           r_tx;
    logic [TW-1:0]  r_timer;
    logic [2:0]     r_bit_index;
    logic [7:0]     r_shift;

    logic [7:0]     r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_overflow;

    logic           w_push_req;
    logic           w_push;
    logic           w_pop;
    logic           w_full;
    logic           w_empty;
    logic           w_overflow_evt;
    logic           w_status_rd;
    logic           w_fsm_busy;
    logic           w_bit_done;
    logic [2:0]     w_next_index;
    logic [7:0]     w_count8;
    logic           w_unused_bits;

    assign w_unused_bits = ^{data_memory_interface_data[31:8],
                             data_memory_interface_frame_mask[2:0]};

    assign w_push_req = data_memory_interface_enable
                      & (data_memory_interface_state == STATE_WRITE)
                      & (data_memory_interface_address == CONSOLE_ADDRESS)
                      & data_memory_interface_frame_mask[3];

    assign w_status_rd = data_memory_interface_enable
                       & (data_memory_interface_state == STATE_READ)
                       & (data_memory_interface_address == STATUS_ADDRESS);

    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_empty    = (r_count == '0);
    assign w_fsm_busy = (r_state != S_IDLE);
    assign w_pop      = (r_state == S_IDLE) & ~w_empty;

    // A full FIFO still accepts a byte when the transmitter frees a slot this cycle
    assign w_push         = w_push_req & (~w_full | w_pop);
    assign w_overflow_evt = w_push_req & w_full & ~w_pop;

    assign w_bit_done   = (r_timer == TW'(CLKS_PER_BIT - 1));
    assign w_next_index = r_bit_index + 3'd1;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_count8
            if (gi < CW) begin : g_bit
                assign w_count8[gi] = r_count[gi];
            end else begin : g_pad
                assign w_count8[gi] = 1'b0;
            end
        end
    endgenerate

    assign read_hit  = w_status_rd;
    assign read_data = w_status_rd
                     ? {16'b0, w_count8, 4'b0, r_overflow, w_empty, w_full, w_fsm_busy}
                     : 32'b0;

    assign uart_tx = r_tx;
    assign tx_busy = w_fsm_busy | ~w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_memory_interface_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_overflow_evt) begin
            r_overflow <= 1'b1;
        end else if (w_status_rd) begin
            r_overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_tx        <= 1'b1;
            r_timer     <= '0;
            r_bit_index <= '0;
            r_shift     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx    <= 1'b1;
                    r_timer <= '0;
                    if (w_pop) begin
                        r_shift <= r_mem[r_rd_ptr];
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_done) begin
                        r_timer     <= '0;
                        r_bit_index <= '0;
                        r_tx        <= r_shift[0];
                        r_state     <= S_DATA;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        if (r_bit_index == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_index <= w_next_index;
                            r_tx        <= r_shift[w_next_index];
                        end
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_done) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_console_uart_tx.sv
// Directed bench for console_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
module tb_console_uart_tx;

    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] CA    = 32'h1000_0000;
    localparam logic        RD    = 1'b0;
    localparam logic        WR    = 1'b1;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        st;
    logic [31:0] addr;
    logic [3:0]  mask;
    logic [31:0] wdata;
    logic [31:0] read_data;
    logic        read_hit;
    logic        uart_tx;
    logic        tx_busy;

    int checks = 0;
    int errors = 0;

    console_uart_tx #(
        .CONSOLE_ADDRESS (CA),
        .FIFO_DEPTH      (DEPTH),
        .CLKS_PER_BIT    (CPB)
    ) dut (
        .clk                              (clk),
        .reset                            (reset),
        .data_memory_interface_enable     (en),
        .data_memory_interface_state      (st),
        .data_memory_interface_address    (addr),
        .data_memory_interface_frame_mask (mask),
        .data_memory_interface_data       (wdata),
        .read_data                        (read_data),
        .read_hit                         (read_hit),
        .uart_tx                          (uart_tx),
        .tx_busy                          (tx_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_idle();
        en    = 1'b0;
        st    = RD;
        addr  = 32'h0;
        mask  = 4'h0;
        wdata = 32'h0;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
        en    = 1'b1;
        st    = WR;
        addr  = a;
        mask  = m;
        wdata = d;
        tick();
        bus_idle();
    endtask

    task automatic status_read(input string tag, input logic [31:0] exp);
        en   = 1'b1;
        st   = RD;
        addr = CA + 32'd4;
        #1;
        check({tag, "_hit"}, {31'b0, read_hit}, 32'd1);
        check(tag, read_data, exp);
        tick();
        bus_idle();
    endtask

    function automatic logic frame_bit(input logic [7:0] b, input int k);
        int idx;
        idx = k / CPB;
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return b[idx-1];
    endfunction

    // Checks uart_tx on every cycle k = first..39 of a frame; cycle 0 is the edge after entry.
    task automatic check_frame(input string tag, input logic [7:0] b, input int first);
        for (int k = first; k < 10 * CPB; k++) begin
            tick();
            check($sformatf("%s_c%0d", tag, k), {31'b0, uart_tx}, {31'b0, frame_bit(b, k)});
        end
    endtask

    task automatic receive(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        int         waited;
        waited = 0;
        got    = 8'h0;
        while (uart_tx !== 1'b0 && waited < 200) begin
            tick();
            waited++;
        end
        check({tag, "_start_seen"}, {31'b0, uart_tx}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            repeat (CPB) tick();
            got[i] = uart_tx;
        end
        repeat (CPB) tick();
        check({tag, "_stop"}, {31'b0, uart_tx}, 32'd1);
        check({tag, "_byte"}, {24'b0, got}, {24'b0, exp});
    endtask

    task automatic wait_idle(input string tag);
        int waited;
        waited = 0;
        while (tx_busy !== 1'b0 && waited < 500) begin
            tick();
            waited++;
        end
        check({tag, "_drained"}, {31'b0, tx_busy}, 32'd0);
    endtask

    initial begin
        logic saw_low;
        bus_idle();
        reset = 1'b1;

        // Reset state
        repeat (3) tick();
        check("rst_uart_tx", {31'b0, uart_tx}, 32'd1);
        check("rst_tx_busy", {31'b0, tx_busy}, 32'd0);
        check("rst_read_hit", {31'b0, read_hit}, 32'd0);
        check("rst_read_data", read_data, 32'd0);
        reset = 1'b0;
        tick();
        status_read("rst_status", 32'h0000_0004);

        // Single byte 'A': frame timing and busy duration
        store(CA, 32'h0000_0041, 4'b1000);
        check("a_tx_at_push", {31'b0, uart_tx}, 32'd1);
        check("a_busy_at_push", {31'b0, tx_busy}, 32'd1);
        check_frame("a", 8'h41, 0);
        check("a_busy_edge40", {31'b0, tx_busy}, 32'd1);
        tick();
        check("a_busy_edge41", {31'b0, tx_busy}, 32'd0);
        check("a_idle_high", {31'b0, uart_tx}, 32'd1);

        // Ignored accesses
        store(CA, 32'h0000_0042, 4'b0100);
        store(CA + 32'd8, 32'h0000_0043, 4'b1000);
        store(CA + 32'd4, 32'h0000_0044, 4'b1000);
        en   = 1'b1;
        st   = RD;
        addr = CA;
        #1;
        check("data_reg_read_hit", {31'b0, read_hit}, 32'd0);
        check("data_reg_read_data", read_data, 32'd0);
        bus_idle();
        saw_low = 1'b0;
        repeat (10) begin
            tick();
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        check("ignored_tx_stays_high", {31'b0, saw_low}, 32'd0);
        check("ignored_busy", {31'b0, tx_busy}, 32'd0);
        status_read("ignored_status", 32'h0000_0004);

        // Overflow: six back-to-back pushes into a depth-4 FIFO
        for (int i = 0; i < 6; i++) begin
            store(CA, 32'h11 * (i + 1), 4'b1000);
        end
        status_read("ovf_status1", 32'h0000_040B);
        status_read("ovf_status2", 32'h0000_0403);
        wait_idle("ovf");
        status_read("ovf_status_after", 32'h0000_0004);

        // Full FIFO with a push coinciding with the IDLE pop
        store(CA, 32'h0000_00A1, 4'b1000);
        store(CA, 32'h0000_003C, 4'b1000);
        store(CA, 32'h0000_00C3, 4'b1000);
        store(CA, 32'h0000_005A, 4'b1000);
        store(CA, 32'h0000_000F, 4'b1000);
        repeat (37) tick();
        check("full_idle_tx", {31'b0, uart_tx}, 32'd1);
        en   = 1'b1;
        st   = RD;
        addr = CA + 32'd4;
        #1;
        check("full_idle_status", read_data, 32'h0000_0402);
        st    = WR;
        addr  = CA;
        mask  = 4'b1000;
        wdata = 32'h0000_00F0;
        tick();
        bus_idle();
        status_read("full_coincident_status", 32'h0000_0403);
        receive("ord0", 8'h3C);
        receive("ord1", 8'hC3);
        receive("ord2", 8'h5A);
        receive("ord3", 8'h0F);
        receive("ord4", 8'hF0);
        wait_idle("ord");

        // Reset during DATA bit 3 of 0x55 with a byte still queued
        store(CA, 32'h0000_0055, 4'b1000);
        store(CA, 32'h0000_0066, 4'b1000);
        repeat (16) tick();
        check("midrst_bit3_low", {31'b0, uart_tx}, 32'd0);
        check("midrst_busy_before", {31'b0, tx_busy}, 32'd1);
        reset = 1'b1;
        tick();
        check("midrst_tx_high", {31'b0, uart_tx}, 32'd1);
        check("midrst_busy", {31'b0, tx_busy}, 32'd0);
        reset = 1'b0;
        status_read("midrst_status", 32'h0000_0004);
        saw_low = 1'b0;
        repeat (60) begin
            tick();
            if (uart_tx !== 1'b1) saw_low = 1'b1;
        end
        check("midrst_no_resume", {31'b0, saw_low}, 32'd0);

        // "Hi\n": three frames, one idle cycle between them
        store(CA, 32'h0000_0048, 4'b1000);
        store(CA, 32'h0000_0069, 4'b1000);
        check("hi_c0", {31'b0, uart_tx}, 32'd0);
        store(CA, 32'h0000_000A, 4'b1000);
        check("hi_c1", {31'b0, uart_tx}, 32'd0);
        check_frame("hi", 8'h48, 2);
        tick();
        check("hi_gap1", {31'b0, uart_tx}, 32'd1);
        check_frame("i", 8'h69, 0);
        tick();
        check("hi_gap2", {31'b0, uart_tx}, 32'd1);
        check_frame("nl", 8'h0A, 0);
        tick();
        check("hi_done_busy", {31'b0, tx_busy}, 32'd0);
        check("hi_done_tx", {31'b0, uart_tx}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
